// File: rtl/pixel_vga_out.sv
// 640x480@60 VGA scan-out of a 160x120 1-bit framebuffer, 4x4 pixel scaling.
// The core writes pixels at any time; the display side reads through a synchronous port.
module pixel_vga_out #(
   parameter int CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pixel_en,
   input  logic        pixel_value,
   input  logic [31:0] pixel_addr,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        vga_blank_n,
   output logic        frame_start
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam int FB_SIZE = 19200;

   logic [DW-1:0] div_cnt;
   logic          pix_tick;
   logic [9:0]    h_cnt;
   logic [9:0]    v_cnt;
   logic          h_last;
   logic          v_last;
   logic          active;
   logic          hsync_next;
   logic          vsync_next;
   logic [14:0]   rd_addr;
   logic          rd_data;
   logic          wr_ok;
   logic          fb [0:FB_SIZE-1];

   assign pix_tick = (div_cnt == DIV_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (pix_tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_tick) begin
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   always_comb begin
      h_last     = (h_cnt == 10'd799);
      v_last     = (v_cnt == 10'd524);
      active     = (h_cnt < 10'd640) && (v_cnt < 10'd480);
      hsync_next = !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
      vsync_next = !((v_cnt >= 10'd490) && (v_cnt <= 10'd491));
      // Address is only meaningful in the active region; park it at 0 elsewhere.
      rd_addr    = active ? (15'(v_cnt[9:2]) * 15'd160 + 15'(h_cnt[9:2])) : 15'd0;
      wr_ok      = pixel_en && !rst && (pixel_addr < 32'd19200);
   end

   // Counters are stable for CLK_DIV >= 2 clocks, so the read issued on any
   // clock of the pixel period is valid by the next tick; reads see pre-write data.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         fb[pixel_addr[14:0]] <= pixel_value;
      end
      rd_data <= fb[rd_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_hsync   <= 1'b1;
         vga_vsync   <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_r       <= 4'h0;
         vga_g       <= 4'h0;
         vga_b       <= 4'h0;
      end else if (pix_tick) begin
         vga_hsync   <= hsync_next;
         vga_vsync   <= vsync_next;
         vga_blank_n <= active;
         vga_r       <= (active && rd_data) ? 4'hF : 4'h0;
         vga_g       <= (active && rd_data) ? 4'hF : 4'h0;
         vga_b       <= (active && rd_data) ? 4'hF : 4'h0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_tick && h_last && v_last;
      end
   end

endmodule
